// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register dump reader.
// Holds the FSM state encoding and the default widths and last dumped index.
package reg_dump_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_LAST_REG = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } dump_state_e;

endpackage

// File: rtl/dump_out_slot.sv
// One-entry valid/ready output buffer for dumped register words.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   i_load          capture i_data/i_idx and mark the slot valid
//   i_flush         drop any held word (takes priority over load)
//   i_ready         consumer accepts the held word when o_valid is high
//   i_data, i_idx   word and its register index to capture
//   o_valid         slot holds an unconsumed word
//   o_data, o_idx   held word and index, stable until consumed or replaced
module dump_out_slot
  import reg_dump_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_flush,
  input  logic              i_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [ADDR_W-1:0] i_idx,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_idx
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      // A load in the same cycle as a pop simply replaces the consumed word.
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_idx   <= i_idx;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_idx   = r_idx;

endmodule

// File: rtl/reg_dump_reader.sv
// Sequentially reads registers 0..LAST_REG through a combinational read port
// and presents them one word at a time on a valid/ready output.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   start            begin a dump (only honoured in IDLE)
//   abort            abandon a dump in progress
//   ra / rd          register file read address / same-cycle read data
//   dump_data/idx    current word and its register index
//   dump_valid       word is pending; dump_ready accepts it
//   busy             dump in progress (READ or DRAIN)
//   done             one-cycle pulse after the last word is accepted
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for start; counter held at 0
// ST_READ  | capturing rd into the output slot whenever it is free
// ST_DRAIN | last word captured; waiting for it to be accepted
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int LAST_REG = DEF_LAST_REG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] rd,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_idx,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic              busy,
  output logic              done
);

  dump_state_e       r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic              r_done, w_done_nxt;
  logic              w_load, w_flush, w_slot_free, w_last, w_valid;

  assign w_slot_free = !w_valid || dump_ready;
  assign w_last      = (r_cnt == ADDR_W'(LAST_REG));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Every exit to IDLE clears the counter so ra reads 0 while idle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_READ;
          w_cnt_nxt   = '0;
        end
      end
      ST_READ: begin
        if (abort) begin
          w_flush     = 1'b1;
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_slot_free) begin
          w_load = 1'b1;
          if (w_last) begin
            w_state_nxt = ST_DRAIN;
          end else begin
            w_cnt_nxt = r_cnt + ADDR_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          w_flush     = 1'b1;
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_valid && dump_ready) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  dump_out_slot #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_slot (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_flush(w_flush),
    .i_ready(dump_ready),
    .i_data (rd),
    .i_idx  (r_cnt),
    .o_valid(w_valid),
    .o_data (dump_data),
    .o_idx  (dump_idx)
  );

  assign ra         = r_cnt;
  assign dump_valid = w_valid;
  assign busy       = (r_state != ST_IDLE);
  assign done       = r_done;

endmodule

// File: tb/tb_reg_dump_reader.sv
module tb_reg_dump_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, dump_ready = 1'b0;
  logic [3:0]  ra, dump_idx;
  logic [31:0] rd, dump_data;
  logic        dump_valid, busy, done;

  logic        start2 = 1'b0, abort2 = 1'b0, ready2 = 1'b0;
  logic [3:0]  ra2, idx2;
  logic [31:0] rd2, data2;
  logic        valid2, busy2, done2;

  logic [31:0] mem [16];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign rd  = mem[ra];
  assign rd2 = mem[ra2];

  reg_dump_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .ra(ra), .rd(rd), .dump_data(dump_data), .dump_idx(dump_idx),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .busy(busy), .done(done)
  );

  reg_dump_reader #(.LAST_REG(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .ra(ra2), .rd(rd2), .dump_data(data2), .dump_idx(idx2),
    .dump_valid(valid2), .dump_ready(ready2), .busy(busy2), .done(done2)
  );

  function automatic logic [31:0] pat_a(input int i);
    return (i == 1) ? 32'd128 : (i == 2) ? 32'd64 : 32'd0;
  endfunction

  function automatic logic [31:0] pat_b(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h111;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       start, abort, ready;
    logic       exp_valid;
    logic [3:0] exp_idx;
    logic       exp_busy, exp_done;
  } vec_t;

  vec_t vt[21];

  initial begin
    int nw;
    logic seen;

    for (int i = 0; i < 16; i++) mem[i] = pat_a(i);

    // reset state
    #2;
    chk("rst_valid", dump_valid, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_ra",    ra, 0);
    chk("rst_data",  dump_data, 0);
    chk("rst_idx",   dump_idx, 0);
    @(negedge clk); rst_n = 1'b1;

    // full dump, ready always high
    @(negedge clk); start = 1'b1; dump_ready = 1'b1;
    step();
    chk("t2_busy0",  busy, 1);
    chk("t2_valid0", dump_valid, 0);
    chk("t2_ra0",    ra, 0);
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("t2_valid", dump_valid, 1);
      chk("t2_idx",   dump_idx, 64'(i));
      chk("t2_data",  dump_data, pat_a(i));
      chk("t2_nodone", done, 0);
    end
    step();
    chk("t2_done",     done, 1);
    chk("t2_valid_end", dump_valid, 0);
    chk("t2_busy_end", busy, 0);
    chk("t2_ra_idle",  ra, 0);
    step();
    chk("t2_done_pulse", done, 0);

    // table: back-pressure, abort, start/abort collision, start while busy
    for (int i = 0; i < 16; i++) mem[i] = pat_b(i);
    vt[0]  = '{1,0,1, 0,4'd0,1,0};
    vt[1]  = '{0,0,1, 1,4'd0,1,0};
    vt[2]  = '{0,0,1, 1,4'd1,1,0};
    vt[3]  = '{0,0,1, 1,4'd2,1,0};
    vt[4]  = '{0,0,1, 1,4'd3,1,0};
    vt[5]  = '{0,0,1, 1,4'd4,1,0};
    vt[6]  = '{0,0,1, 1,4'd5,1,0};
    vt[7]  = '{0,0,0, 1,4'd5,1,0};
    vt[8]  = '{0,0,0, 1,4'd5,1,0};
    vt[9]  = '{0,0,0, 1,4'd5,1,0};
    vt[10] = '{0,0,1, 1,4'd6,1,0};
    vt[11] = '{0,0,1, 1,4'd7,1,0};
    vt[12] = '{0,0,0, 1,4'd7,1,0};
    vt[13] = '{0,1,0, 0,4'd0,0,0};
    vt[14] = '{0,0,0, 0,4'd0,0,0};
    vt[15] = '{1,1,0, 0,4'd0,1,0};
    vt[16] = '{0,0,1, 1,4'd0,1,0};
    vt[17] = '{1,0,1, 1,4'd1,1,0};
    vt[18] = '{0,0,1, 1,4'd2,1,0};
    vt[19] = '{0,1,1, 0,4'd0,0,0};
    vt[20] = '{0,0,1, 0,4'd0,0,0};
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      start = vt[k].start; abort = vt[k].abort; dump_ready = vt[k].ready;
      step();
      chk($sformatf("tab%0d_valid", k), dump_valid, vt[k].exp_valid);
      chk($sformatf("tab%0d_busy", k),  busy, vt[k].exp_busy);
      chk($sformatf("tab%0d_done", k),  done, vt[k].exp_done);
      if (vt[k].exp_valid) begin
        chk($sformatf("tab%0d_idx", k),  dump_idx, vt[k].exp_idx);
        chk($sformatf("tab%0d_data", k), dump_data, pat_b(int'(vt[k].exp_idx)));
      end
    end
    @(negedge clk); start = 1'b0; abort = 1'b0;

    // asynchronous reset mid-dump
    @(negedge clk); start = 1'b1; dump_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_valid", dump_valid, 0);
    chk("ar_data",  dump_data, 0);
    chk("ar_idx",   dump_idx, 0);
    chk("ar_ra",    ra, 0);
    chk("ar_busy",  busy, 0);
    chk("ar_done",  done, 0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ar_idle_busy",  busy, 0);
      chk("ar_idle_valid", dump_valid, 0);
    end

    // start held high for the whole dump
    @(negedge clk); start = 1'b1; dump_ready = 1'b1;
    nw = 0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      step();
      if (dump_valid) begin
        chk("sh_idx", dump_idx, 64'(nw));
        nw++;
      end
      if (done) seen = 1'b1;
    end
    chk("sh_done_seen", seen, 1);
    chk("sh_words", nw, 16);
    step();
    chk("sh_restart_busy",  busy, 1);
    chk("sh_restart_valid", dump_valid, 0);
    step();
    chk("sh_restart_valid1", dump_valid, 1);
    chk("sh_restart_idx",    dump_idx, 0);
    @(negedge clk); start = 1'b0; abort = 1'b1;
    step();
    chk("sh_abort_busy", busy, 0);
    @(negedge clk); abort = 1'b0;

    // LAST_REG = 3 instance
    @(negedge clk); start2 = 1'b1; ready2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    nw = 0; seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (valid2) begin
        chk("l3_idx",  idx2, 64'(nw));
        chk("l3_data", data2, pat_b(nw));
        nw++;
      end
      if (done2) seen = 1'b1;
    end
    chk("l3_done_seen", seen, 1);
    chk("l3_words", nw, 4);
    chk("l3_busy_end", busy2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 4, register address width; register count 2**ADDR_W.
REQ-003 Parameter LAST_REG, default 15, highest register index dumped.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request a dump; sampled only in IDLE.
REQ-007 abort  input  1  synchronous abandon of a dump in progress.
REQ-008 ra  output  ADDR_W  read address to register file read port.
REQ-009 rd  input  DATA_W  combinational read data for ra, valid in same cycle.
REQ-010 dump_data  output  DATA_W  captured register value.
REQ-011 dump_idx  output  ADDR_W  index of the register in dump_data.
REQ-012 dump_valid  output  1  dump_data/dump_idx hold an unconsumed word.
REQ-013 dump_ready  input  1  consumer accepts the word when high with dump_valid.
REQ-014 busy  output  1  high in READ or DRAIN.
REQ-015 done  output  1  one-cycle pulse after last word accepted.

Function
REQ-016 States IDLE, READ and DRAIN shall be used, encoded by a shared enum.
REQ-017 IDLE: start=1 -> READ, address counter cleared to 0; otherwise stay; ra shall equal 0.
REQ-018 ra shall be driven directly from the registered address counter, with no combinational path from any input.
REQ-019 READ: output slot free (dump_valid=0, or dump_valid=1 and dump_ready=1) -> capture rd into dump_data and ra into dump_idx, set dump_valid, increment counter.
REQ-020 READ with slot occupied and dump_ready=0: counter, dump_data, dump_idx and dump_valid shall hold.
REQ-021 Capture of counter value LAST_REG -> DRAIN, with no counter increment.
REQ-022 DRAIN: dump_valid && dump_ready -> clear dump_valid, pulse done for exactly one cycle, go to IDLE.
REQ-023 Throughput: one word per cycle while dump_ready stays high; first word valid on the cycle after start is sampled.
REQ-024 Words shall be emitted in strictly ascending index 0..LAST_REG, with none skipped or repeated.
REQ-025 dump_data and dump_idx shall be stable while dump_valid=1 and dump_ready=0.
REQ-026 abort in READ or DRAIN -> IDLE next cycle, dump_valid cleared, no done pulse; abort has priority over capture.
REQ-027 start while busy shall be ignored.
REQ-028 Simultaneous start and abort in IDLE: start wins.
REQ-029 The counter shall be ADDR_W bits wide and shall never wrap past LAST_REG.

Reset
REQ-030 rst_n low shall immediately force IDLE, counter=0, ra=0, dump_valid=0, dump_data=0, dump_idx=0, busy=0 and done=0.
REQ-031 Reset mid-dump shall discard the pending word; after release, the block shall wait in IDLE for a new start.

Structure
REQ-032 Package reg_dump_pkg shall hold the state enum, the DATA_W/ADDR_W defaults and LAST_REG default.
REQ-033 The output holding register shall be a sub-module, dump_out_slot, a one-entry valid/ready buffer.
REQ-034 No memories; the design shall be flip-flops only.

Verification
REQ-035 Behavioural 16x32 register model with r1=128, r2=64 and others 0; start pulse, dump_ready=1 -> 16 consecutive words, idx 0..15, word1=128, word2=64, done on the cycle after idx 15 is accepted.
REQ-036 Back-pressure: dump_ready low for 3 cycles at idx 5 -> dump_data/dump_idx held at 5; sequence resumes at 6 with no loss.
REQ-037 Abort asserted while idx 7 is pending -> dump_valid=0 next cycle, IDLE, no done; a new start restarts at idx 0.
REQ-038 rst_n pulsed low mid-dump, asynchronous to clk -> all outputs 0 immediately; no activity until the next start.
REQ-039 start held high for the whole dump -> exactly one dump; start still high afterwards -> next dump begins on the cycle after done.
REQ-040 LAST_REG=3 -> exactly 4 words (idx 0..3), then done.
